pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the yadan core. It replaces the fixed, stall-vector-driven inter-stage registers with a generic valid/ready stage carrying an arbitrary-width payload, a synchronous flush, and an optional 2-entry skid buffer. The skid buffer gives full throughput with a registered `in_ready`. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Each instance also exports a saturating back-pressure counter for performance analysis.

---
 rtl/pipe_stage_reg_pkg.sv | 13 +
 rtl/pipe_stage_reg_if.sv | 13 +
 rtl/pipe_sat_cnt.sv | 26 ++
 rtl/pipe_stage_reg.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and defaults for the valid/ready pipeline stage register.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    PipeStEmpty = 2'd0,
    PipeStOne   = 2'd1,
    PipeStTwo   = 2'd2
  } pipe_st_e;

  localparam int unsigned DEF_DW = 160;
  localparam int unsigned DEF_CW = 16;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// One valid/ready/payload link between two pipeline stages.
interface pipe_stage_reg_if #(
  parameter int unsigned DW = 160
) ();

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_cnt #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [CW-1:0] o_q
);

  logic [CW-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage with flush, optional 2-entry skid buffer
// and a saturating back-pressure counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned   DW        = DEF_DW,
  parameter int unsigned   SKID      = 1,
  parameter logic [DW-1:0] NOP_VALUE = '0,
  parameter int unsigned   CW        = DEF_CW
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_reg_if.slave   s_in,
  pipe_stage_reg_if.master  m_out,
  input  logic              i_flush,
  input  logic              i_clr_stats,
  output logic [CW-1:0]     o_stall_cnt
);

  logic          w_in_ready;
  logic          w_out_valid;
  logic [DW-1:0] w_out_data;
  logic          w_stall_inc;

  generate
    if (SKID != 0) begin : g_skid
      pipe_st_e      r_state;
      pipe_st_e      w_state_next;
      logic [DW-1:0] r_main;
      logic [DW-1:0] r_skid;
      logic [DW-1:0] w_main_next;
      logic [DW-1:0] w_skid_next;
      logic          r_in_ready;
      logic          w_in_fire;
      logic          w_out_fire;

      assign w_in_fire  = s_in.valid & r_in_ready;
      assign w_out_fire = (r_state != PipeStEmpty) & m_out.ready;

      always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;
        if (i_flush) begin
          w_state_next = PipeStEmpty;
          w_main_next  = NOP_VALUE;
          w_skid_next  = NOP_VALUE;
        end else begin
          case (r_state)
            PipeStEmpty: begin
              if (w_in_fire) begin
                w_state_next = PipeStOne;
                w_main_next  = s_in.data;
              end
            end
            PipeStOne: begin
              if (w_in_fire && w_out_fire) begin
                w_main_next = s_in.data;
              end else if (w_in_fire) begin
                w_state_next = PipeStTwo;
                w_skid_next  = s_in.data;
              end else if (w_out_fire) begin
                w_state_next = PipeStEmpty;
                w_main_next  = NOP_VALUE;
              end
            end
            PipeStTwo: begin
              // in_ready is low here, so only the drain transition exists
              if (w_out_fire) begin
                w_state_next = PipeStOne;
                w_main_next  = r_skid;
                w_skid_next  = NOP_VALUE;
              end
            end
            default: begin
              w_state_next = PipeStEmpty;
              w_main_next  = NOP_VALUE;
              w_skid_next  = NOP_VALUE;
            end
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_state    <= PipeStEmpty;
          r_main     <= NOP_VALUE;
          r_skid     <= NOP_VALUE;
          r_in_ready <= 1'b1;
        end else begin
          r_state    <= w_state_next;
          r_main     <= w_main_next;
          r_skid     <= w_skid_next;
          r_in_ready <= (w_state_next != PipeStTwo);
        end
      end

      assign w_in_ready  = r_in_ready;
      assign w_out_valid = (r_state != PipeStEmpty);
      assign w_out_data  = r_main;
    end else begin : g_single
      logic          r_valid;
      logic [DW-1:0] r_main;
      logic          w_in_fire;
      logic          w_out_fire;

      // Accepts whenever the held payload leaves in the same cycle.
      assign w_in_ready = ~r_valid | m_out.ready;
      assign w_in_fire  = s_in.valid & w_in_ready;
      assign w_out_fire = r_valid & m_out.ready;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_valid <= 1'b0;
          r_main  <= NOP_VALUE;
        end else if (i_flush) begin
          r_valid <= 1'b0;
          r_main  <= NOP_VALUE;
        end else if (w_in_fire) begin
          r_valid <= 1'b1;
          r_main  <= s_in.data;
        end else if (w_out_fire) begin
          r_valid <= 1'b0;
          r_main  <= NOP_VALUE;
        end
      end

      assign w_out_valid = r_valid;
      assign w_out_data  = r_main;
    end
  endgenerate

  assign s_in.ready  = w_in_ready;
  assign m_out.valid = w_out_valid;
  assign m_out.data  = w_out_data;

  assign w_stall_inc = w_out_valid & ~m_out.ready;

  pipe_sat_cnt #(
    .CW (CW)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall_inc),
    .i_clr (i_clr_stats),
    .o_q   (o_stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1 and a SKID=0 stage with shared stimulus; each is compared
// every cycle against a queue-based model of the stage contents.
module tb_pipe_stage_reg;

  localparam logic [7:0] NOP = 8'hEE;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       flush = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] cnt1;
  logic [3:0] cnt0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DW(8)) in1 ();
  pipe_stage_reg_if #(.DW(8)) out1 ();
  pipe_stage_reg_if #(.DW(8)) in0 ();
  pipe_stage_reg_if #(.DW(8)) out0 ();

  assign in1.valid  = in_valid;
  assign in1.data   = in_data;
  assign out1.ready = out_ready;
  assign in0.valid  = in_valid;
  assign in0.data   = in_data;
  assign out0.ready = out_ready;

  pipe_stage_reg #(.DW(8), .SKID(1), .NOP_VALUE(NOP), .CW(4)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .s_in        (in1),
    .m_out       (out1),
    .i_flush     (flush),
    .i_clr_stats (clr),
    .o_stall_cnt (cnt1)
  );

  pipe_stage_reg #(.DW(8), .SKID(0), .NOP_VALUE(NOP), .CW(4)) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .s_in        (in0),
    .m_out       (out0),
    .i_flush     (flush),
    .i_clr_stats (clr),
    .o_stall_cnt (cnt0)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each stage is just an ordered list of held payloads.
  logic [7:0] q1[$];
  logic [7:0] q0[$];
  bit         mir1 = 1'b1;
  int         st1 = 0;
  int         st0 = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1.delete();
      q0.delete();
      mir1 = 1'b1;
      st1  = 0;
      st0  = 0;
    end else begin
      bit if1, of1, if0, of0;
      if1 = in_valid && mir1;
      of1 = (q1.size() > 0) && out_ready;
      if0 = in_valid && ((q0.size() == 0) || out_ready);
      of0 = (q0.size() > 0) && out_ready;
      if (clr) st1 = 0;
      else if ((q1.size() > 0) && !out_ready && (st1 < 15)) st1 = st1 + 1;
      if (clr) st0 = 0;
      else if ((q0.size() > 0) && !out_ready && (st0 < 15)) st0 = st0 + 1;
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (of1) void'(q1.pop_front());
        if (if1) q1.push_back(in_data);
        if (of0) void'(q0.pop_front());
        if (if0) q0.push_back(in_data);
      end
      mir1 = (q1.size() < 2);
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst) begin
      check("skid1_out_valid", int'(out1.valid), int'(q1.size() > 0));
      check("skid1_out_data", int'(out1.data), (q1.size() > 0) ? int'(q1[0]) : int'(NOP));
      check("skid1_in_ready", int'(in1.ready), int'(mir1));
      check("skid1_stall_cnt", int'(cnt1), st1);
      check("skid0_out_valid", int'(out0.valid), int'(q0.size() > 0));
      check("skid0_out_data", int'(out0.data), (q0.size() > 0) ? int'(q0[0]) : int'(NOP));
      check("skid0_in_ready", int'(in0.ready), int'((q0.size() == 0) || out_ready));
      check("skid0_stall_cnt", int'(cnt0), st0);
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic r,
                     input logic f = 1'b0, input logic c = 1'b0);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    clr       = c;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #2;
    check("reset_out_valid", int'(out1.valid), 0);
    check("reset_out_data", int'(out1.data), int'(NOP));
    check("reset_in_ready", int'(in1.ready), 1);
    check("reset_stall_cnt", int'(cnt1), 0);
    check("reset0_out_data", int'(out0.data), int'(NOP));

    // back-to-back streaming
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 8'(k), 1'b1);
      if (k > 1) begin
        #2;
        check("stream_skid1_data", int'(out1.data), k - 1);
        check("stream_skid0_data", int'(out0.data), k - 1);
      end
    end
    cyc(1'b0, 8'h00, 1'b1);
    #2;
    check("stream_last_data", int'(out1.data), 8);
    check("stream_stall_cnt", int'(cnt1), 0);

    // back-pressure into the skid entry
    cyc(1'b1, 8'h0A, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 8'h0B, 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    #2;
    check("bp_in_ready_low", int'(in1.ready), 0);
    check("bp_head_data", int'(out1.data), 8'h0A);
    cyc(1'b0, 8'h00, 1'b1);
    #2;
    check("bp_stall_cnt", int'(cnt1), 4);
    cyc(1'b0, 8'h00, 1'b1);
    #2;
    check("bp_second_data", int'(out1.data), 8'h0B);
    cyc(1'b0, 8'h00, 1'b1);
    #2;
    check("bp_drained", int'(out1.valid), 0);

    // flush while full, with a payload offered
    cyc(1'b1, 8'h21, 1'b1);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h0C, 1'b0, 1'b1);
    #2;
    check("flush_full_in_ready", int'(in1.ready), 0);
    cyc(1'b0, 8'h00, 1'b0);
    #2;
    check("flush_out_valid", int'(out1.valid), 0);
    check("flush_out_data", int'(out1.data), int'(NOP));
    check("flush_in_ready", int'(in1.ready), 1);

    // counter saturation and clear during stall
    cyc(1'b1, 8'h5A, 1'b0);
    repeat (20) cyc(1'b0, 8'h00, 1'b0);
    #2;
    check("sat_skid1_cnt", int'(cnt1), 15);
    check("sat_skid0_cnt", int'(cnt0), 15);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    #2;
    check("clr_skid1_cnt", int'(cnt1), 0);
    check("clr_skid0_cnt", int'(cnt0), 0);
    cyc(1'b0, 8'h00, 1'b1);

    // asynchronous reset while holding two payloads
    cyc(1'b1, 8'h11, 1'b1);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("areset_out_valid", int'(out1.valid), 0);
    check("areset_out_data", int'(out1.data), int'(NOP));
    check("areset_in_ready", int'(in1.ready), 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) cyc(1'b0, 8'h00, 1'b1);

    // alternating downstream under continuous input
    for (int i = 0; i < 200; i++) cyc(1'b1, 8'($urandom), (i % 2) == 0);

    // fully random traffic
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
    end
    cyc(1'b0, 8'h00, 1'b1);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
